// File: rtl/pc_fetch.sv
// MIPS32 program counter and instruction fetch stage: req/ack fetch from imem, one-entry output register to decode.
// Optional ALIGN_CHECK_EN: misaligned redirects load FAULT_PC and set the sticky fetch_fault flag.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] FAULT_PC = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [5:0]  j_order,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  typedef enum logic {S_REQ, S_OUT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] redir_tgt;
  logic        redir_bad;
  logic        ack_ok;

`ifdef ALIGN_CHECK_EN
  always_comb begin
    redir_bad = (redirect_pc[1:0] != 2'b00);
    redir_tgt = redir_bad ? FAULT_PC : redirect_pc;
  end
`else
  logic unused_cfg;
  always_comb begin
    redir_bad  = 1'b0;
    redir_tgt  = {redirect_pc[31:2], 2'b00};
    unused_cfg = ^{redirect_pc[1:0], FAULT_PC};
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      inst_q    <= '0;
      pc_out_q  <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      inst_q    <= inst_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

  // req_q is registered so the request rises one edge after reset releases;
  // an ack is only meaningful while the request is actually visible.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    inst_d    = inst_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    ack_ok    = req_q & imem_ack;
    case (state_q)
      S_REQ: begin
        if (ack_ok) begin
          if (redirect_valid) begin
            pc_d    = redir_tgt;
            pend_d  = 1'b0;
            fault_d = fault_q | redir_bad;
          end else if (pend_q) begin
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
          end else begin
            inst_d   = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
            state_d  = S_OUT;
          end
        end else if (redirect_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = redir_tgt;
          fault_d   = fault_q | redir_bad;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          valid_d = 1'b0;
          fault_d = fault_q | redir_bad;
          state_d = S_REQ;
        end else if (inst_ready) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    req_d = (state_d == S_REQ);
  end

  always_comb begin
    imem_req    = req_q;
    imem_addr   = pc_q;
    inst_valid  = valid_q;
    inst_out    = inst_q;
    pc_out      = pc_out_q;
    pc_plus4    = pc_out_q + 32'd4;
    j_order     = inst_q[31:26];
    fetch_fault = fault_q;
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: directed fetches push expected words, a monitor checks each new inst_valid.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_out, pc_out, pc_plus4;
  logic [5:0]  j_order;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  logic        w_req, w_ack, w_valid, w_ready, w_fault;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc_out, w_pc_plus4;
  logic [5:0]  w_j;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [5:0]  j;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_fetch u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .j_order(j_order),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .inst_valid(w_valid), .inst_ready(w_ready), .inst_out(w_inst), .pc_out(w_pc_out),
    .pc_plus4(w_pc_plus4), .j_order(w_j),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .fetch_fault(w_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] pc4, input logic [5:0] j);
    exp_t e;
    e.pc = pc; e.inst = inst; e.pc4 = pc4; e.j = j;
    sb.push_back(e);
  endtask

  task automatic serve(input logic [31:0] a, input logic [31:0] d, input int unsigned waits);
    int unsigned n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, a);
    repeat (waits) begin
      @(negedge clk);
      chk("addr_hold", imem_addr, a);
    end
    imem_ack = 1'b1; imem_rdata = d;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = '0;
  endtask

  // Monitor: every rising inst_valid must match the oldest expected fetch.
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (inst_valid && !valid_prev) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got pc %h inst %h expected none", pc_out, inst_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_pc_out", pc_out, e.pc);
        chk("mon_inst_out", inst_out, e.inst);
        chk("mon_pc_plus4", pc_plus4, e.pc4);
        chk("mon_j_order", {26'b0, j_order}, {26'b0, e.j});
      end
    end
    valid_prev = inst_valid;
  end

  logic [31:0] exp_al;
  logic        exp_f;

  initial begin
`ifdef ALIGN_CHECK_EN
    exp_al = 32'h0000_0180; exp_f = 1'b1;
`else
    exp_al = 32'h0000_0040; exp_f = 1'b0;
`endif
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    w_ack = 1'b0; w_rdata = '0; w_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);

    // First fetch with one wait cycle, then 5 cycles of backpressure.
    push(32'h0, 32'h2408_0005, 32'h4, 6'b001001);
    serve(32'h0, 32'h2408_0005, 1);
    repeat (5) begin
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_inst", inst_out, 32'h2408_0005);
      chk("bp_pc_out", pc_out, 32'h0);
      chk("bp_req", {31'b0, imem_req}, 32'd0);
      @(negedge clk);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("next_addr", imem_addr, 32'h4);

    push(32'h4, 32'h8C09_0004, 32'h8, 6'b100011);
    serve(32'h4, 32'h8C09_0004, 0);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;

    // Redirect during a wait-state fetch: address holds, data discarded.
    chk("wait_addr", imem_addr, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0; redirect_pc = '0;
    chk("pend_addr", imem_addr, 32'h8);
    chk("pend_req", {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    chk("pend_addr2", imem_addr, 32'h8);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = '0;
    chk("discard_valid", {31'b0, inst_valid}, 32'd0);
    chk("discard_req", {31'b0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h40);

    // Redirect in OUT together with inst_ready: redirect wins.
    push(32'h40, 32'h0800_0010, 32'h44, 6'b000010);
    serve(32'h40, 32'h0800_0010, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h100; inst_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    chk("out_redir_valid", {31'b0, inst_valid}, 32'd0);
    chk("out_redir_req", {31'b0, imem_req}, 32'd1);
    chk("out_redir_addr", imem_addr, 32'h100);

    // Misaligned redirect.
    push(32'h100, 32'h1000_0003, 32'h104, 6'b000100);
    serve(32'h100, 32'h1000_0003, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    @(negedge clk);
    redirect_valid = 1'b0; redirect_pc = '0;
    chk("align_valid", {31'b0, inst_valid}, 32'd0);
    chk("align_addr", imem_addr, exp_al);
    chk("align_fault", {31'b0, fetch_fault}, {31'b0, exp_f});
    push(exp_al, 32'h2129_0001, exp_f ? 32'h184 : 32'h44, 6'b001000);
    serve(exp_al, 32'h2129_0001, 0);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("fault_sticky", {31'b0, fetch_fault}, {31'b0, exp_f});
    chk("after_align_addr", imem_addr, exp_f ? 32'h184 : 32'h44);

    // PC wrap on the second instance.
    chk("wrap_req", {31'b0, w_req}, 32'd1);
    w_ack = 1'b1; w_rdata = 32'h0000_0000;
    @(negedge clk);
    w_ack = 1'b0;
    chk("wrap_valid", {31'b0, w_valid}, 32'd1);
    chk("wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", w_pc_plus4, 32'h0);
    w_ready = 1'b1;
    @(negedge clk);
    w_ready = 1'b0;
    chk("wrap_next_req", {31'b0, w_req}, 32'd1);
    chk("wrap_next_addr", w_addr, 32'h0);

    // Reset again clears the sticky fault.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst2_req", {31'b0, imem_req}, 32'd0);

    @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
